// File: rtl/rr_grant_scheduler_pkg.sv
// Shared types, default sizing and helpers for the round-robin grant scheduler.
// The scheduler FSM states and the one-hot grant encoder live here.
package grant_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_HOLD_CYC = 2;
    localparam int DEF_MAX_WAIT = 16;
    localparam int MAX_REQ      = 16;
    localparam int MAX_ID_W     = 4;

    // Wide enough for the largest legal requester count; callers truncate.
    function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_ID_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_grant_scheduler_if.sv
// Requester/resource side bundle of the scheduler. The master drives requests and
// resource readiness; the slave (the scheduler) returns grants and status.
interface rr_grant_scheduler_if
    import grant_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0] req;
    logic               res_ready;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               active;
    logic [NUM_REQ-1:0] starve;

    modport master (
        output req, res_ready,
        input  gnt, gnt_id, active, starve
    );

    modport slave (
        input  req, res_ready,
        output gnt, gnt_id, active, starve
    );
endinterface

// File: rtl/rr_grant_scheduler_pick.sv
// Combinational round-robin picker: first set request at or above the pointer,
// wrapping modulo NUM_REQ.
module rr_pick
    import grant_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic               o_valid,
    output logic [ID_W-1:0]    o_idx
);
    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [ID_W:0]        w_sum;

    // Rotating a doubled copy puts the pointer's requester at bit 0.
    assign w_dbl = {i_req, i_req};
    assign w_rot = NUM_REQ'(w_dbl >> i_ptr);

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_sum   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = {1'b0, i_ptr} + (ID_W + 1)'(k);
                if (w_sum >= (ID_W + 1)'(NUM_REQ)) begin
                    w_sum = w_sum - (ID_W + 1)'(NUM_REQ);
                end
                o_valid = 1'b1;
                o_idx   = w_sum[ID_W-1:0];
            end
        end
    end
endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin scheduler: samples requests in IDLE, pulses a one-hot grant the next
// cycle, keeps the resource owned for HOLD_CYC cycles and flags starving requesters.
module rr_grant_scheduler
    import grant_sched_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int HOLD_CYC = DEF_HOLD_CYC,
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int ID_W     = $clog2(NUM_REQ)
) (
    input logic             clk,
    input logic             rst_n,
    rr_grant_scheduler_if.slave bus
);
    localparam int HC_W      = (HOLD_CYC > 2) ? $clog2(HOLD_CYC - 1) : 1;
    localparam int HOLD_LOAD = (HOLD_CYC > 1) ? HOLD_CYC - 2 : 0;
    localparam int WT_W      = $clog2(MAX_WAIT + 1);

    state_e             r_state;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_gnt_id;
    logic [HC_W-1:0]    r_hold;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] r_starve;
    logic               r_active;
    logic [WT_W-1:0]    r_wait [NUM_REQ];

    logic               w_valid;
    logic [ID_W-1:0]    w_win;

    rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_valid (w_valid),
        .o_idx   (w_win)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_active <= 1'b0;
            r_hold   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid && bus.res_ready) begin
                        r_gnt    <= NUM_REQ'(onehot(MAX_ID_W'(w_win)));
                        r_gnt_id <= w_win;
                        r_active <= 1'b1;
                        r_ptr    <= (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + ID_W'(1);
                        r_state  <= GRANT;
                    end else begin
                        r_gnt <= '0;
                    end
                end
                GRANT: begin
                    r_gnt <= '0;
                    if (HOLD_CYC > 1) begin
                        r_state <= HOLD;
                        r_hold  <= HC_W'(HOLD_LOAD);
                    end else begin
                        r_state  <= IDLE;
                        r_active <= 1'b0;
                    end
                end
                HOLD: begin
                    if (r_hold == '0) begin
                        r_state  <= IDLE;
                        r_active <= 1'b0;
                    end else begin
                        r_hold <= r_hold - HC_W'(1);
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_gnt    <= '0;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    // A requester waits on any cycle it asks without holding the grant pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_wait[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req[i] && !r_gnt[i]) begin
                    if (r_wait[i] != WT_W'(MAX_WAIT)) begin
                        r_wait[i] <= r_wait[i] + WT_W'(1);
                    end
                    if (r_wait[i] >= WT_W'(MAX_WAIT - 1)) begin
                        r_starve[i] <= 1'b1;
                    end
                end else begin
                    r_wait[i] <= '0;
                end
            end
        end
    end

    assign bus.gnt    = r_gnt;
    assign bus.gnt_id = r_gnt_id;
    assign bus.active = r_active;
    assign bus.starve = r_starve;
endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Self-checking bench for rr_grant_scheduler: directed scenarios plus a randomized
// run compared against an ownership-countdown reference model.
module tb_rr_grant_scheduler;
    localparam int N    = 4;
    localparam int HOLD = 2;
    localparam int MAXW = 16;

    logic clk;
    logic rst_n;

    rr_grant_scheduler_if #(.NUM_REQ(N), .ID_W(2)) bus ();
    rr_grant_scheduler_if #(.NUM_REQ(N), .ID_W(2)) bus1 ();

    rr_grant_scheduler #(.NUM_REQ(N), .HOLD_CYC(HOLD), .MAX_WAIT(MAXW), .ID_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    rr_grant_scheduler #(.NUM_REQ(N), .HOLD_CYC(1), .MAX_WAIT(MAXW), .ID_W(2)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: ownership countdown, pointer and wait counts as plain ints.
    int         m_left;
    int         m_ptr;
    int         m_wait [N];
    logic [1:0] m_id;
    logic [3:0] m_gnt;
    logic [3:0] m_starve;
    logic       m_active;

    task automatic model_reset();
        m_left = 0; m_ptr = 0; m_id = '0; m_gnt = '0; m_starve = '0; m_active = 1'b0;
        for (int i = 0; i < N; i++) m_wait[i] = 0;
    endtask

    task automatic model_step();
        logic [3:0] r;
        int         w;
        r = bus.req;
        w = -1;
        for (int i = 0; i < N; i++) begin
            if (r[i] && !m_gnt[i]) begin
                if (m_wait[i] < MAXW) m_wait[i]++;
                if (m_wait[i] >= MAXW) m_starve[i] = 1'b1;
            end else begin
                m_wait[i] = 0;
            end
        end
        m_gnt = '0;
        if (m_left == 0) begin
            if (r != 0 && bus.res_ready) begin
                for (int k = N - 1; k >= 0; k--)
                    if (r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                m_gnt    = 4'(1 << w);
                m_id     = 2'(w);
                m_active = 1'b1;
                m_left   = HOLD;
                m_ptr    = (w + 1) % N;
            end
        end else begin
            m_left--;
            if (m_left == 0) m_active = 1'b0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic go_idle();
        bus.req = '0;
        for (int i = 0; i < 4; i++) cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req = '0; bus.res_ready = 1'b0;
        bus1.req = '0; bus1.res_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({bus.gnt, bus.gnt_id, bus.active, bus.starve} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_state: got gnt=%b id=%0d act=%b stv=%b, want all 0",
                     bus.gnt, bus.gnt_id, bus.active, bus.starve);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        n_vec++;
        if ({bus.gnt, bus.active} !== 5'd0) begin
            n_err++;
            $display("FAIL idle_no_req: got gnt=%b act=%b, want 0 0", bus.gnt, bus.active);
        end
    endtask

    task automatic test_single();
        bus.req = 4'b0010; bus.res_ready = 1'b1;
        cycle();
        n_vec++;
        if ({bus.gnt, bus.gnt_id, bus.active} !== {4'b0010, 2'd1, 1'b1}) begin
            n_err++;
            $display("FAIL single_grant: got gnt=%b id=%0d act=%b, want 0010 1 1",
                     bus.gnt, bus.gnt_id, bus.active);
        end
        bus.req = '0;
        cycle();
        n_vec++;
        if ({bus.gnt, bus.active} !== {4'b0000, 1'b1}) begin
            n_err++;
            $display("FAIL single_hold: got gnt=%b act=%b, want 0000 1", bus.gnt, bus.active);
        end
        cycle();
        n_vec++;
        if ({bus.gnt, bus.active} !== 5'd0) begin
            n_err++;
            $display("FAIL single_release: got gnt=%b act=%b, want 0000 0", bus.gnt, bus.active);
        end
        // Pointer now at 2: requester 3 must beat requester 0.
        bus.req = 4'b1001;
        cycle();
        n_vec++;
        if ({bus.gnt, bus.gnt_id} !== {4'b1000, 2'd3}) begin
            n_err++;
            $display("FAIL ptr_after_single: got gnt=%b id=%0d, want 1000 3", bus.gnt, bus.gnt_id);
        end
        go_idle();
    endtask

    task automatic test_all_four();
        int ids[$];
        int tms[$];
        bus.req = 4'b1111;
        for (int c = 0; c < 20 && ids.size() < 4; c++) begin
            cycle();
            n_vec++;
            if ($countones(bus.gnt) > 1) begin
                n_err++;
                $display("FAIL onehot: got gnt=%b, want at most one bit", bus.gnt);
            end
            if (bus.gnt != 0) begin
                ids.push_back(int'(bus.gnt_id));
                tms.push_back(c);
            end
            bus.req = bus.req & ~m_gnt;
        end
        n_vec++;
        if (ids.size() != 4) begin
            n_err++;
            $display("FAIL all_four_count: got %0d grants, want 4", ids.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_vec++;
                if (ids[k] != k) begin
                    n_err++;
                    $display("FAIL all_four_order[%0d]: got id %0d, want %0d", k, ids[k], k);
                end
                if (k > 0) begin
                    n_vec++;
                    if (tms[k] - tms[k-1] != HOLD + 1) begin
                        n_err++;
                        $display("FAIL all_four_spacing[%0d]: got %0d, want %0d",
                                 k, tms[k] - tms[k-1], HOLD + 1);
                    end
                end
            end
        end
        go_idle();
    endtask

    task automatic test_wrap();
        bus.req = 4'b0010;
        cycle();
        n_vec++;
        if (bus.gnt_id !== 2'd1) begin
            n_err++;
            $display("FAIL wrap_setup: got id %0d, want 1", bus.gnt_id);
        end
        bus.req = '0;
        cycle(); cycle();
        bus.req = 4'b0011;
        cycle();
        n_vec++;
        if ({bus.gnt, bus.gnt_id} !== {4'b0001, 2'd0}) begin
            n_err++;
            $display("FAIL wrap_first: got gnt=%b id=%0d, want 0001 0", bus.gnt, bus.gnt_id);
        end
        bus.req = 4'b0010;
        cycle(); cycle(); cycle();
        n_vec++;
        if ({bus.gnt, bus.gnt_id} !== {4'b0010, 2'd1}) begin
            n_err++;
            $display("FAIL wrap_second: got gnt=%b id=%0d, want 0010 1", bus.gnt, bus.gnt_id);
        end
        go_idle();
    endtask

    task automatic test_starve();
        bus.req = 4'b0100; bus.res_ready = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            n_vec++;
            if ({bus.gnt, bus.active, bus.starve} !== {4'b0000, 1'b0, (k >= MAXW) ? 4'b0100 : 4'b0000}) begin
                n_err++;
                $display("FAIL starve_wait[%0d]: got gnt=%b act=%b stv=%b, want 0000 0 %b",
                         k, bus.gnt, bus.active, bus.starve, (k >= MAXW) ? 4'b0100 : 4'b0000);
            end
        end
        bus.res_ready = 1'b1;
        cycle();
        n_vec++;
        if ({bus.gnt, bus.starve} !== {4'b0100, 4'b0100}) begin
            n_err++;
            $display("FAIL starve_grant: got gnt=%b stv=%b, want 0100 0100", bus.gnt, bus.starve);
        end
        go_idle();
    endtask

    task automatic test_reset_mid();
        bus.req = 4'b0100; bus.res_ready = 1'b1;
        cycle();
        bus.req = '0;
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.gnt, bus.gnt_id, bus.active, bus.starve} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_mid: got gnt=%b id=%0d act=%b stv=%b, want all 0",
                     bus.gnt, bus.gnt_id, bus.active, bus.starve);
        end
        model_reset();
        bus.req = 4'b1000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        n_vec++;
        if ({bus.gnt, bus.gnt_id, bus.active} !== {4'b1000, 2'd3, 1'b1}) begin
            n_err++;
            $display("FAIL reset_release: got gnt=%b id=%0d act=%b, want 1000 3 1",
                     bus.gnt, bus.gnt_id, bus.active);
        end
        go_idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            cycle();
            n_vec++;
            if ({bus.gnt, bus.gnt_id, bus.active, bus.starve} !== {m_gnt, m_id, m_active, m_starve}) begin
                n_err++;
                $display("FAIL random[%0d]: got gnt=%b id=%0d act=%b stv=%b, want %b %0d %b %b",
                         c, bus.gnt, bus.gnt_id, bus.active, bus.starve, m_gnt, m_id, m_active, m_starve);
            end
            bus.req = bus.req & ~m_gnt;
            for (int i = 0; i < N; i++)
                if (!m_gnt[i] && $urandom_range(0, 3) == 0) bus.req[i] = 1'b1;
            bus.res_ready = (c % 100 < 60) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
        end
        go_idle();
    endtask

    task automatic test_hold1();
        bus1.req = 4'b0001; bus1.res_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            n_vec++;
            if ({bus1.gnt, bus1.gnt_id, bus1.active} !== {(k % 2 == 1) ? 4'b0001 : 4'b0000, 2'd0, k % 2 == 1}) begin
                n_err++;
                $display("FAIL hold1[%0d]: got gnt=%b id=%0d act=%b, want %b 0 %b",
                         k, bus1.gnt, bus1.gnt_id, bus1.active,
                         (k % 2 == 1) ? 4'b0001 : 4'b0000, k % 2 == 1);
            end
        end
        bus1.req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_wrap();
        test_starve();
        test_reset_mid();
        test_random();
        test_hold1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end
endmodule
